// File: rtl/mmio_bridge.sv
// Processor IO bus to MMIO slot bus bridge: decodes one IO transaction into a
// single-cycle access on one of 32 slots and returns a one-cycle ready/response.
module mmio_bridge #(
    parameter logic [7:0] BRIDGE_BASE = 8'hC0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          io_addr_strobe,
    input  logic          io_read_strobe,
    input  logic          io_write_strobe,
    input  logic [31:0]   io_address,
    input  logic [3:0]    io_byte_enable,
    input  logic [31:0]   io_write_data,
    output logic [31:0]   io_read_data,
    output logic          io_ready,
    output logic          io_err,
    output logic [31:0]   slot_cs,
    output logic          slot_read,
    output logic          slot_write,
    output logic [4:0]    slot_addr,
    output logic [31:0]   slot_wr_data,
    input  logic [1023:0] slot_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state_q, state_d;

    logic [4:0]  req_slot_q, req_slot_d;
    logic        req_read_q, req_read_d;
    logic        req_err_q, req_err_d;

    logic [31:0] slot_cs_q, slot_cs_d;
    logic        slot_read_q, slot_read_d;
    logic        slot_write_q, slot_write_d;
    logic [4:0]  slot_addr_q, slot_addr_d;
    logic [31:0] slot_wr_data_q, slot_wr_data_d;
    logic        io_ready_q, io_ready_d;
    logic        io_err_q, io_err_d;
    logic [31:0] io_read_data_q, io_read_data_d;

    logic        req_err;
    logic [4:0]  req_slot;
    logic [31:0] slot_rd_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{io_address[23:12], io_address[1:0]};

    assign req_slot = io_address[11:7];

    // Strobe pair must be exactly one-hot; writes must cover the full word.
    assign req_err = (io_address[31:24] != BRIDGE_BASE)
                  || (io_read_strobe == io_write_strobe)
                  || (io_write_strobe && (io_byte_enable != 4'hF));

    assign slot_rd_word = slot_rd_data[{req_slot_q, 5'd0} +: 32];

    always_comb begin
        state_d        = state_q;
        req_slot_d     = req_slot_q;
        req_read_d     = req_read_q;
        req_err_d      = req_err_q;
        slot_cs_d      = '0;
        slot_read_d    = 1'b0;
        slot_write_d   = 1'b0;
        slot_addr_d    = '0;
        slot_wr_data_d = '0;
        io_ready_d     = 1'b0;
        io_err_d       = 1'b0;
        io_read_data_d = '0;

        unique case (state_q)
            IDLE: begin
                if (io_addr_strobe) begin
                    state_d    = ACCESS;
                    req_slot_d = req_slot;
                    req_read_d = io_read_strobe;
                    req_err_d  = req_err;
                    if (!req_err) begin
                        slot_cs_d      = 32'd1 << req_slot;
                        slot_read_d    = io_read_strobe;
                        slot_write_d   = io_write_strobe;
                        slot_addr_d    = io_address[6:2];
                        slot_wr_data_d = io_write_data;
                    end
                end
            end
            ACCESS: begin
                state_d    = RESP;
                io_ready_d = 1'b1;
                io_err_d   = req_err_q;
                if (!req_err_q && req_read_q) begin
                    io_read_data_d = slot_rd_word;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            req_slot_q     <= '0;
            req_read_q     <= 1'b0;
            req_err_q      <= 1'b0;
            slot_cs_q      <= '0;
            slot_read_q    <= 1'b0;
            slot_write_q   <= 1'b0;
            slot_addr_q    <= '0;
            slot_wr_data_q <= '0;
            io_ready_q     <= 1'b0;
            io_err_q       <= 1'b0;
            io_read_data_q <= '0;
        end else begin
            state_q        <= state_d;
            req_slot_q     <= req_slot_d;
            req_read_q     <= req_read_d;
            req_err_q      <= req_err_d;
            slot_cs_q      <= slot_cs_d;
            slot_read_q    <= slot_read_d;
            slot_write_q   <= slot_write_d;
            slot_addr_q    <= slot_addr_d;
            slot_wr_data_q <= slot_wr_data_d;
            io_ready_q     <= io_ready_d;
            io_err_q       <= io_err_d;
            io_read_data_q <= io_read_data_d;
        end
    end

    assign slot_cs      = slot_cs_q;
    assign slot_read    = slot_read_q;
    assign slot_write   = slot_write_q;
    assign slot_addr    = slot_addr_q;
    assign slot_wr_data = slot_wr_data_q;
    assign io_ready     = io_ready_q;
    assign io_err       = io_err_q;
    assign io_read_data = io_read_data_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed vector bench for mmio_bridge with a simple 32-slot read-data model.
module tb_mmio_bridge;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [31:0]   io_address, io_write_data, io_read_data;
    logic [3:0]    io_byte_enable;
    logic          io_ready, io_err;
    logic [31:0]   slot_cs, slot_wr_data;
    logic          slot_read, slot_write;
    logic [4:0]    slot_addr;
    logic [1023:0] slot_rd_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_bridge #(.BRIDGE_BASE(8'hC0)) dut (
        .clk(clk), .reset(reset),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready), .io_err(io_err),
        .slot_cs(slot_cs), .slot_read(slot_read), .slot_write(slot_write),
        .slot_addr(slot_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data(slot_rd_data)
    );

    // Slot i returns {i, 16'hBEEF, 3'b0, slot_addr}; slot 1 reg 0 returns 0x12345678.
    always_comb begin
        slot_rd_data = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == 1 && slot_addr == 5'd0)
                slot_rd_data[i*32 +: 32] = 32'h1234_5678;
            else
                slot_rd_data[i*32 +: 32] = {i[7:0], 16'hBEEF, 3'b000, slot_addr};
        end
    end

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        rd, wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_cs;
        logic        exp_srd, exp_swr;
        logic [4:0]  exp_sa;
        logic [31:0] exp_swd;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_address      = '0;
        io_byte_enable  = '0;
        io_write_data   = '0;
    endtask

    task automatic drive(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] wd);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = a;
        io_byte_enable  = be;
        io_write_data   = wd;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".ready"}, {31'd0, io_ready}, 32'd0);
        chk({nm, ".err"}, {31'd0, io_err}, 32'd0);
        chk({nm, ".rdata"}, io_read_data, 32'd0);
        chk({nm, ".cs"}, slot_cs, 32'd0);
        chk({nm, ".srd_swr"}, {30'd0, slot_read, slot_write}, 32'd0);
        chk({nm, ".sa"}, {27'd0, slot_addr}, 32'd0);
        chk({nm, ".swd"}, slot_wr_data, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        drive(v.addr, v.rd, v.wr, v.be, v.wdata);
        step();
        idle_inputs();
        chk({v.name, ".cs"}, slot_cs, v.exp_cs);
        chk({v.name, ".srd"}, {31'd0, slot_read}, {31'd0, v.exp_srd});
        chk({v.name, ".swr"}, {31'd0, slot_write}, {31'd0, v.exp_swr});
        chk({v.name, ".acc_ready"}, {31'd0, io_ready}, 32'd0);
        if (!v.exp_err) begin
            chk({v.name, ".sa"}, {27'd0, slot_addr}, {27'd0, v.exp_sa});
            chk({v.name, ".swd"}, slot_wr_data, v.exp_swd);
        end
        step();
        chk({v.name, ".ready"}, {31'd0, io_ready}, 32'd1);
        chk({v.name, ".err"}, {31'd0, io_err}, {31'd0, v.exp_err});
        chk({v.name, ".rdata"}, io_read_data, v.exp_rdata);
        chk({v.name, ".resp_cs"}, slot_cs, 32'd0);
        step();
        chk_quiet({v.name, ".after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name        addr          rd wr be     wdata          cs            srd swr sa     swd           err rdata
        vecs[0] = '{"wr_timer", 32'hC000_0088, 0, 1, 4'hF, 32'h0000_0001, 32'h0000_0002, 0, 1, 5'd2,  32'h0000_0001, 0, 32'h0};
        vecs[1] = '{"rd_slot1", 32'hC000_0080, 1, 0, 4'hF, 32'h0000_0000, 32'h0000_0002, 1, 0, 5'd0,  32'h0000_0000, 0, 32'h1234_5678};
        vecs[2] = '{"rd_slot31",32'hC000_0F84, 1, 0, 4'h0, 32'h0000_0000, 32'h8000_0000, 1, 0, 5'd1,  32'h0000_0000, 0, 32'h1FBE_EF01};
        vecs[3] = '{"err_space",32'hB000_0080, 1, 0, 4'hF, 32'h0000_0000, 32'h0000_0000, 0, 0, 5'd0,  32'h0000_0000, 1, 32'h0};
        vecs[4] = '{"err_be",   32'hC000_0080, 0, 1, 4'h3, 32'h5555_AAAA, 32'h0000_0000, 0, 0, 5'd0,  32'h0000_0000, 1, 32'h0};
        vecs[5] = '{"err_both", 32'hC000_0080, 1, 1, 4'hF, 32'h0000_0000, 32'h0000_0000, 0, 0, 5'd0,  32'h0000_0000, 1, 32'h0};
        vecs[6] = '{"err_none", 32'hC000_0080, 0, 0, 4'hF, 32'h0000_0000, 32'h0000_0000, 0, 0, 5'd0,  32'h0000_0000, 1, 32'h0};
        vecs[7] = '{"wr_s5r31", 32'hC0AB_C2FF, 0, 1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0020, 0, 1, 5'd31, 32'hDEAD_BEEF, 0, 32'h0};
        vecs[8] = '{"rd_s0r3",  32'hC000_000C, 1, 0, 4'hF, 32'h0000_0000, 32'h0000_0001, 1, 0, 5'd3,  32'h0000_0000, 0, 32'h00BE_EF03};

        idle_inputs();
        reset = 1'b0;
        step();
        step();
        chk_quiet("reset");
        reset = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Back-to-back: strobe held for cycles N and N+1, then a new one at N+3.
        drive(32'hC000_0080, 1'b1, 1'b0, 4'hF, 32'h0);
        step();
        chk("b2b.cs", slot_cs, 32'h0000_0002);
        step();
        idle_inputs();
        chk("b2b.ready", {31'd0, io_ready}, 32'd1);
        chk("b2b.rdata", io_read_data, 32'h1234_5678);
        chk("b2b.no_cs", slot_cs, 32'd0);
        step();
        chk_quiet("b2b.n3");
        drive(32'hC000_0088, 1'b0, 1'b1, 4'hF, 32'h0000_0007);
        step();
        idle_inputs();
        chk("b2b.n4_cs", slot_cs, 32'h0000_0002);
        chk("b2b.n4_swr", {31'd0, slot_write}, 32'd1);
        chk("b2b.n4_swd", slot_wr_data, 32'h0000_0007);
        chk("b2b.n4_ready", {31'd0, io_ready}, 32'd0);
        step();
        chk("b2b.n5_ready", {31'd0, io_ready}, 32'd1);
        chk("b2b.n5_err", {31'd0, io_err}, 32'd0);
        step();
        chk_quiet("b2b.n6");

        // Reset during ACCESS drops the transaction.
        drive(32'hC000_0088, 1'b0, 1'b1, 4'hF, 32'h0000_0001);
        step();
        idle_inputs();
        chk("rst_acc.cs", slot_cs, 32'h0000_0002);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_quiet("rst_acc.n2");
        step();
        chk_quiet("rst_acc.n3");

        // Reset coincident with a strobe suppresses the slot access.
        drive(32'hC000_0080, 1'b1, 1'b0, 4'hF, 32'h0);
        reset = 1'b0;
        step();
        idle_inputs();
        reset = 1'b1;
        chk_quiet("rst_strb.n1");
        step();
        chk_quiet("rst_strb.n2");

        run_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
